// File: rtl/equation_solver.sv
// Gauss-Jordan solver for A*x = b with partial pivoting, signed fixed point.
// The augmented matrix is latched on a command; x is streamed out over a stb/ack handshake.
module equation_solver #(
    parameter int unsigned MATRIX_SIZE = 3,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned FRAC_BITS   = 16
) (
    input  logic                                               i_clk,
    input  logic                                               i_rst,
    input  logic                                               i_calc_cmd,
    input  logic [DATA_WIDTH*MATRIX_SIZE*(MATRIX_SIZE+1)-1:0] i_matrix,
    output logic                                               input_ack,
    output logic [DATA_WIDTH-1:0]                              output_z,
    output logic                                               output_z_stb,
    input  logic                                               output_z_ack,
    output logic                                               output_err
);

    localparam int unsigned N    = MATRIX_SIZE;
    localparam int unsigned DW   = DATA_WIDTH;
    localparam int unsigned FB   = FRAC_BITS;
    localparam int unsigned QW   = DW + FB;
    localparam int unsigned RowW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned ColW = $clog2(N + 1);
    localparam int unsigned CntW = $clog2(QW + 1);

    localparam logic [RowW-1:0] LastRow = RowW'(N - 1);
    localparam logic [ColW-1:0] LastCol = ColW'(N);
    localparam logic [DW-1:0]   FixOne  = DW'(1) << FB;

    typedef enum logic [3:0] {
        StIdle, StLoad, StPivot, StSwap, StNorm, StDiv, StDivWr, StElim, StOutput
    } state_e;

    state_e state_q, state_d;

    logic signed [DW-1:0] mat_q [N][N+1];
    logic signed [DW-1:0] mat_d [N][N+1];

    logic [RowW-1:0] k_q, k_d;
    logic [RowW-1:0] row_q, row_d;
    logic [ColW-1:0] col_q, col_d;
    logic [RowW-1:0] piv_row_q, piv_row_d;
    logic [DW-1:0]   piv_abs_q, piv_abs_d;
    logic [RowW-1:0] out_q, out_d;
    logic [QW-1:0]   div_q, div_d;
    logic [DW-1:0]   rem_q, rem_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            neg_q, neg_d;
    logic            err_q, err_d;
    logic signed [DW-1:0] fac_q, fac_d;

    logic [ColW-1:0]      kc;
    logic signed [DW-1:0] piv_el, num, den, fac, elim_val;
    logic [DW-1:0]        cur_abs, num_abs, den_abs, pick_abs, quot;
    logic [RowW-1:0]      pick_row;
    logic [DW:0]          div_shift;
    logic                 div_ge;
    logic signed [QW-1:0] prod;

    always_comb begin
        kc        = ColW'(k_q);
        piv_el    = mat_q[row_q][kc];
        cur_abs   = piv_el[DW-1] ? -piv_el : piv_el;
        // Strict compare keeps the lowest row index on ties.
        pick_abs  = (cur_abs > piv_abs_q) ? cur_abs : piv_abs_q;
        pick_row  = (cur_abs > piv_abs_q) ? row_q : piv_row_q;
        num       = mat_q[k_q][col_q];
        den       = mat_q[k_q][kc];
        num_abs   = num[DW-1] ? -num : num;
        den_abs   = den[DW-1] ? -den : den;
        div_shift = {rem_q, div_q[QW-1]};
        div_ge    = div_shift >= {1'b0, den_abs};
        quot      = div_q[DW-1:0];
        // The row factor must be captured before a(i,k) is overwritten on the first column.
        fac       = (col_q == kc) ? mat_q[row_q][kc] : fac_q;
        // Low QW bits of the full product are enough for the >>> FB result kept at DW bits.
        prod      = QW'(fac) * QW'(mat_q[k_q][col_q]);
        elim_val  = mat_q[row_q][col_q] - DW'(prod >>> FB);
    end

    always_comb begin
        state_d   = state_q;
        mat_d     = mat_q;
        k_d       = k_q;
        row_d     = row_q;
        col_d     = col_q;
        piv_row_d = piv_row_q;
        piv_abs_d = piv_abs_q;
        out_d     = out_q;
        div_d     = div_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        err_d     = err_q;
        fac_d     = fac_q;

        unique case (state_q)
            StIdle: begin
                if (i_calc_cmd) state_d = StLoad;
            end
            StLoad: begin
                for (int unsigned r = 0; r < N; r++) begin
                    for (int unsigned c = 0; c <= N; c++) begin
                        mat_d[r][c] = i_matrix[DW*(r*(N+1)+c) +: DW];
                    end
                end
                err_d     = 1'b0;
                k_d       = '0;
                row_d     = '0;
                piv_row_d = '0;
                piv_abs_d = '0;
                state_d   = StPivot;
            end
            StPivot: begin
                piv_abs_d = pick_abs;
                piv_row_d = pick_row;
                if (row_q == LastRow) begin
                    if (pick_abs == '0) begin
                        err_d   = 1'b1;
                        out_d   = '0;
                        state_d = StOutput;
                    end else if (pick_row != k_q) begin
                        state_d = StSwap;
                    end else begin
                        col_d   = kc + 1'b1;
                        state_d = StNorm;
                    end
                end else begin
                    row_d = row_q + 1'b1;
                end
            end
            StSwap: begin
                for (int unsigned c = 0; c <= N; c++) begin
                    mat_d[k_q][c]       = mat_q[piv_row_q][c];
                    mat_d[piv_row_q][c] = mat_q[k_q][c];
                end
                col_d   = kc + 1'b1;
                state_d = StNorm;
            end
            StNorm: begin
                neg_d   = num[DW-1] ^ den[DW-1];
                div_d   = {num_abs, {FB{1'b0}}};
                rem_d   = '0;
                cnt_d   = CntW'(QW);
                state_d = StDiv;
            end
            StDiv: begin
                rem_d = div_ge ? (div_shift[DW-1:0] - den_abs) : div_shift[DW-1:0];
                div_d = {div_q[QW-2:0], div_ge};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CntW'(1)) state_d = StDivWr;
            end
            StDivWr: begin
                mat_d[k_q][col_q] = neg_q ? -quot : quot;
                if (col_q == LastCol) begin
                    mat_d[k_q][kc] = FixOne;
                    row_d          = '0;
                    col_d          = kc;
                    state_d        = StElim;
                end else begin
                    col_d   = col_q + 1'b1;
                    state_d = StNorm;
                end
            end
            StElim: begin
                if (row_q != k_q) begin
                    mat_d[row_q][col_q] = elim_val;
                    fac_d               = fac;
                end
                if (row_q != k_q && col_q != LastCol) begin
                    col_d = col_q + 1'b1;
                end else begin
                    col_d = kc;
                    if (row_q == LastRow) begin
                        if (k_q == LastRow) begin
                            out_d   = '0;
                            state_d = StOutput;
                        end else begin
                            k_d       = k_q + 1'b1;
                            row_d     = k_q + 1'b1;
                            piv_row_d = k_q + 1'b1;
                            piv_abs_d = '0;
                            state_d   = StPivot;
                        end
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
            end
            StOutput: begin
                if (output_z_ack) begin
                    if (out_q == LastRow) begin
                        err_d   = 1'b0;
                        state_d = StIdle;
                    end else begin
                        out_d = out_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= StIdle;
            k_q       <= '0;
            row_q     <= '0;
            col_q     <= '0;
            piv_row_q <= '0;
            piv_abs_q <= '0;
            out_q     <= '0;
            div_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            err_q     <= 1'b0;
            fac_q     <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            row_q     <= row_d;
            col_q     <= col_d;
            piv_row_q <= piv_row_d;
            piv_abs_q <= piv_abs_d;
            out_q     <= out_d;
            div_q     <= div_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            err_q     <= err_d;
            fac_q     <= fac_d;
        end
    end

    // Matrix contents are only meaningful after a LOAD, so they need no reset.
    always_ff @(posedge i_clk) begin
        mat_q <= mat_d;
    end

    always_comb begin
        input_ack    = (state_q == StLoad);
        output_z_stb = (state_q == StOutput);
        output_err   = err_q;
        output_z     = (state_q == StOutput && !err_q) ? mat_q[out_q][LastCol] : '0;
    end

endmodule

// File: tb/tb_equation_solver.sv
// Directed bench for equation_solver: table of systems plus backpressure and reset sequences.
module tb_equation_solver;

    localparam int N  = 3;
    localparam int DW = 32;
    localparam int MW = DW * N * (N + 1);

    localparam logic [31:0] P0  = 32'h0000_0000;
    localparam logic [31:0] P1  = 32'h0001_0000;
    localparam logic [31:0] P2  = 32'h0002_0000;
    localparam logic [31:0] P5  = 32'h0005_0000;
    localparam logic [31:0] M1  = 32'hFFFF_0000;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd;
    logic [MW-1:0] mat;
    logic          in_ack;
    logic [DW-1:0] z;
    logic          stb;
    logic          ack_in;
    logic          err;

    equation_solver #(
        .MATRIX_SIZE(N),
        .DATA_WIDTH (DW),
        .FRAC_BITS  (16)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_calc_cmd  (cmd),
        .i_matrix    (mat),
        .input_ack   (in_ack),
        .output_z    (z),
        .output_z_stb(stb),
        .output_z_ack(ack_in),
        .output_err  (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0][31:0] m;
        logic [2:0][31:0]  x;
        int                tol;
        logic              err;
    } vec_t;

    vec_t vecs[4];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [11:0][31:0] mk(
        input logic [31:0] a00, a01, a02, a03,
        input logic [31:0] a10, a11, a12, a13,
        input logic [31:0] a20, a21, a22, a23);
        return {a23, a22, a21, a20, a13, a12, a11, a10, a03, a02, a01, a00};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp,
                         input int tol);
        int d;
        n_checks++;
        d = $signed(act - exp);
        if (d > tol || d < -tol) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (tol %0d)", nm, act, exp, tol);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_cmd(input logic [MW-1:0] m, input string tag);
        bit ok;
        ok  = 1'b0;
        mat = m;
        cmd = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (in_ack) begin
                ok = 1'b1;
                break;
            end
        end
        cmd = 1'b0;
        check({tag, "_ack_seen"}, 32'(ok), 32'd1, 0);
        tick();
        check({tag, "_ack_pulse"}, 32'(in_ack), 32'd0, 0);
    endtask

    task automatic wait_stb(input string tag, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (stb) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check({tag, "_stb_timeout"}, 32'(ok), 32'd1, 0);
    endtask

    task automatic read_words(input int v, input string tag);
        bit ok;
        for (int w = 0; w < N; w++) begin
            wait_stb($sformatf("%s_w%0d", tag, w), ok);
            if (!ok) return;
            check($sformatf("%s_z%0d", tag, w), z, vecs[v].x[w], vecs[v].tol);
            check($sformatf("%s_err%0d", tag, w), 32'(err), 32'(vecs[v].err), 0);
            ack_in = 1'b1;
            tick();
            ack_in = 1'b0;
        end
        check({tag, "_stb_drop"}, 32'(stb), 32'd0, 0);
        check({tag, "_err_clear"}, 32'(err), 32'd0, 0);
    endtask

    initial begin
        bit ok;

        // Identity, b = 1.25, -3, 7
        vecs[0].m   = mk(P1, P0, P0, 32'h0001_4000,
                         P0, P1, P0, 32'hFFFD_0000,
                         P0, P0, P1, 32'h0007_0000);
        vecs[0].x   = {32'h0007_0000, 32'hFFFD_0000, 32'h0001_4000};
        vecs[0].tol = 0;
        vecs[0].err = 1'b0;
        // Pivot forces a swap of rows 0 and 1
        vecs[1].m   = mk(P0, P1, P0, P2,
                         P1, P0, P0, P5,
                         P0, P0, P1, M1);
        vecs[1].x   = {M1, P2, P5};
        vecs[1].tol = 0;
        vecs[1].err = 1'b0;
        // x+y+z=6, 2y+5z=-4, 2x+5y-z=27
        vecs[2].m   = mk(P1, P1, P1, 32'h0006_0000,
                         P0, P2, P5, 32'hFFFC_0000,
                         P2, P5, M1, 32'h001B_0000);
        vecs[2].x   = {32'hFFFE_0000, 32'h0003_0000, 32'h0005_0000};
        vecs[2].tol = 4;
        vecs[2].err = 1'b0;
        // Singular: row 2 equals row 0
        vecs[3].m   = mk(P1, P0, P1, P2,
                         P0, P1, P1, 32'h0003_0000,
                         P1, P0, P1, P2);
        vecs[3].x   = {P0, P0, P0};
        vecs[3].tol = 0;
        vecs[3].err = 1'b1;

        rst    = 1'b1;
        cmd    = 1'b0;
        ack_in = 1'b0;
        mat    = '0;
        repeat (3) tick();
        check("rst_input_ack", 32'(in_ack), 32'd0, 0);
        check("rst_output_z", z, 32'd0, 0);
        check("rst_stb", 32'(stb), 32'd0, 0);
        check("rst_err", 32'(err), 32'd0, 0);
        rst = 1'b0;
        tick();

        for (int v = 0; v < 4; v++) begin
            start_cmd(vecs[v].m, $sformatf("vec%0d", v));
            read_words(v, $sformatf("vec%0d", v));
            repeat (2) tick();
        end

        // Backpressure: stb held with ack low, output must not move
        start_cmd(vecs[1].m, "bp");
        wait_stb("bp_first", ok);
        if (ok) begin
            for (int i = 0; i < 20; i++) begin
                check($sformatf("bp_hold_z%0d", i), z, P5, 0);
                check($sformatf("bp_hold_stb%0d", i), 32'(stb), 32'd1, 0);
                tick();
            end
        end
        read_words(1, "bp");
        repeat (3) tick();
        start_cmd(vecs[0].m, "after_bp");
        read_words(0, "after_bp");

        // Reset while eliminating the first pivot column
        repeat (2) tick();
        start_cmd(vecs[2].m, "mid");
        repeat (156) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_input_ack", 32'(in_ack), 32'd0, 0);
        check("mid_rst_output_z", z, 32'd0, 0);
        check("mid_rst_stb", 32'(stb), 32'd0, 0);
        check("mid_rst_err", 32'(err), 32'd0, 0);
        repeat (5) tick();
        check("mid_rst_idle_stb", 32'(stb), 32'd0, 0);
        start_cmd(vecs[2].m, "fresh");
        read_words(2, "fresh");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/equation_solver.md
Name: equation_solver

Overview:
- Solves a dense linear system A·x = b of order MATRIX_SIZE by Gauss-Jordan elimination with partial pivoting.
- The augmented matrix [A|b] is presented in parallel on one packed bus and latched on a command. The solution x0..x(N-1) is then streamed out one word at a time over a strobe/ack handshake.
- Used as a coprocessor in the matrix-ops datapath.
- Arithmetic is signed two's-complement fixed point with FRAC_BITS fractional bits, default Q16.16.

Parameters:
- MATRIX_SIZE, 3, system order N (2..8); the matrix holds N rows by N+1 columns.
- DATA_WIDTH, 32, width of every element and result word.
- FRAC_BITS, 16, number of fractional bits in each element (less than DATA_WIDTH).

Ports:
- i_clk  in  1  clock; all logic is on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_calc_cmd  in  1  start request; level-sampled in IDLE.
- i_matrix  in  DATA_WIDTH*N*(N+1)  augmented matrix; element (r,c) is at [DATA_WIDTH*(r*(N+1)+c) +: DATA_WIDTH]; column N is b.
- input_ack  out  1  one-cycle pulse: matrix latched; i_matrix may change afterwards.
- output_z  out  DATA_WIDTH  current solution element.
- output_z_stb  out  1  output_z is valid.
- output_z_ack  in  1  consumer accepts output_z.
- output_err  out  1  system is singular; valid while output_z_stb is high.

Behaviour:
- Reset values: input_ack=0, output_z=0, output_z_stb=0, output_err=0; FSM enters IDLE. Reset at any point aborts work and discards the internal matrix.
- IDLE → LOAD: on i_calc_cmd=1. LOAD copies all elements into an internal register array and pulses input_ack for exactly one cycle. i_calc_cmd is ignored outside IDLE.
- For each pivot column k = 0..N-1:
  - PIVOT: scan rows k..N-1 one row per cycle and keep the row with the largest |a(r,k)|. Ties keep the lowest row index.
  - Singular case: if the maximum is 0, set the error flag and go to OUTPUT with every x = 0.
  - SWAP: exchange row k and the pivot row; 1 cycle; skipped if they are the same row.
  - NORM: a(k,c) = (a(k,c) << FRAC_BITS) / a(k,k) for c = k+1..N, then a(k,k) = 1.0.
  - The divide is a sequential restoring divider on a (DATA_WIDTH+FRAC_BITS)-bit magnitude, taking about DATA_WIDTH+FRAC_BITS cycles per element. Signs are applied afterwards, so the quotient truncates toward zero.
  - ELIM: for every row i ≠ k, f = a(i,k); then a(i,c) = a(i,c) − ((f·a(k,c)) >>> FRAC_BITS) for c = k..N.
  - The product is 2·DATA_WIDTH wide with an arithmetic shift (truncation toward −∞). The result is kept as the low DATA_WIDTH bits, wrapping on overflow with no saturation.
  - One multiply-subtract per cycle is permitted.
- OUTPUT:
  - Present x_i = a(i,N) for i = 0..N-1 in ascending order.
  - output_z_stb=1 and output_z holds steady until output_z_ack=1 on a clock edge; then i advances the next cycle.
  - The acceptance edge may coincide with the first cycle of stb.
  - On acceptance of x(N-1): stb drops, output_err clears, FSM returns to IDLE.
- output_err is 1 for all N words of a singular result, else 0.
- Latency: LOAD to first stb is bounded by N·(N + N·(DATA_WIDTH+FRAC_BITS+2) + N·(N+1) + 4) cycles. It depends only on N and the pivot path, never on data values beyond the swap and singular decisions.
- A new command is only accepted after the last output is acked.

Test Plan:
- Identity A, b = {0x00014000, 0xFFFD0000, 0x00070000} (1.25, −3, 7) → one input_ack pulse, then outputs exactly 0x00014000, 0xFFFD0000, 0x00070000 with output_err=0.
- Pivot/swap: rows [0 1 0 | 2], [1 0 0 | 5], [0 0 1 | −1] → 0x00050000, 0x00020000, 0xFFFF0000.
- General: x+y+z=6, 2y+5z=−4, 2x+5y−z=27 → 5, 3, −2. Each result must be within ±4 LSB of 0x00050000, 0x00030000, 0xFFFE0000.
- Singular: row 2 = row 0 → three words 0x00000000, each with output_err=1; returns to IDLE.
- Backpressure: hold output_z_ack low 20 cycles with stb high → output_z stable. Then ack one cycle per word → exactly N words. A later i_calc_cmd is accepted normally.
- Reset mid-ELIM: assert i_rst for 1 cycle → all outputs 0 next cycle. A fresh command then yields correct results.
